// File: rtl/tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_frame_arbiter
// Brief    : Round-robin arbiter for three frame requesters feeding one UART
//            byte serializer, with an optional per-frame header byte.
// Revision : 1.0 - initial release
// ============================================================================
module tx_frame_arbiter #(
    parameter int HEADER_EN = 1
) (
    input  logic        i_clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [47:0] req_data,
    input  logic [5:0]  req_len,
    output logic [2:0]  ack,
    output logic [2:0]  done,
    output logic [7:0]  tx_data,
    output logic        tx_go,
    input  logic        tx_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic c_HDR_EN = (HEADER_EN != 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_last_grant;
    logic [1:0]  w_last_grant_nxt;
    logic [1:0]  r_id;
    logic [1:0]  w_id_nxt;
    logic [1:0]  r_len;
    logic [1:0]  w_len_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic        r_is_hdr;
    logic        w_is_hdr_nxt;
    logic [15:0] r_data;
    logic [15:0] w_data_nxt;
    logic [7:0]  r_tx_data;
    logic [7:0]  w_tx_data_nxt;
    logic        r_tx_go;
    logic        w_tx_go_nxt;
    logic [2:0]  r_ack;
    logic [2:0]  w_ack_nxt;
    logic [2:0]  r_done;
    logic [2:0]  w_done_nxt;

    logic [1:0]  w_grant_id;
    logic [15:0] w_grant_data;
    logic [1:0]  w_grant_len_raw;
    logic [1:0]  w_grant_len;

    // Round-robin search starts just after the previous winner.
    always_comb begin
        w_grant_id = 2'd0;
        case (r_last_grant)
            2'd0: begin
                if (req[1])      w_grant_id = 2'd1;
                else if (req[2]) w_grant_id = 2'd2;
                else             w_grant_id = 2'd0;
            end
            2'd1: begin
                if (req[2])      w_grant_id = 2'd2;
                else if (req[0]) w_grant_id = 2'd0;
                else             w_grant_id = 2'd1;
            end
            default: begin
                if (req[0])      w_grant_id = 2'd0;
                else if (req[1]) w_grant_id = 2'd1;
                else             w_grant_id = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_grant_data    = req_data[15:0];
        w_grant_len_raw = req_len[1:0];
        case (w_grant_id)
            2'd0: begin
                w_grant_data    = req_data[15:0];
                w_grant_len_raw = req_len[1:0];
            end
            2'd1: begin
                w_grant_data    = req_data[31:16];
                w_grant_len_raw = req_len[3:2];
            end
            default: begin
                w_grant_data    = req_data[47:32];
                w_grant_len_raw = req_len[5:4];
            end
        endcase
        w_grant_len = (w_grant_len_raw == 2'd3) ? 2'd2 : w_grant_len_raw;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_id_nxt         = r_id;
        w_len_nxt        = r_len;
        w_cnt_nxt        = r_cnt;
        w_is_hdr_nxt     = r_is_hdr;
        w_data_nxt       = r_data;
        w_tx_data_nxt    = r_tx_data;
        w_tx_go_nxt      = r_tx_go;
        w_ack_nxt        = 3'b000;
        w_done_nxt       = 3'b000;

        case (r_state)
            ST_IDLE: begin
                if (req != 3'b000) begin
                    w_id_nxt   = w_grant_id;
                    w_data_nxt = w_grant_data;
                    w_len_nxt  = w_grant_len;
                    // Byte budget covers the header too, so WAIT needs one counter.
                    w_cnt_nxt  = w_grant_len + {1'b0, c_HDR_EN};
                    w_ack_nxt  = 3'b001 << w_grant_id;
                    if (c_HDR_EN)
                        w_state_nxt = ST_HDR;
                    else if (w_grant_len == 2'd0)
                        w_state_nxt = ST_DONE;
                    else
                        w_state_nxt = ST_SEND;
                end
            end
            ST_HDR: begin
                w_tx_data_nxt = {4'hA, r_id, r_len};
                w_tx_go_nxt   = 1'b1;
                w_is_hdr_nxt  = 1'b1;
                w_state_nxt   = ST_WAIT;
            end
            ST_SEND: begin
                w_tx_data_nxt = r_data[7:0];
                w_tx_go_nxt   = 1'b1;
                w_is_hdr_nxt  = 1'b0;
                w_state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_ready) begin
                    w_tx_go_nxt = 1'b0;
                    w_cnt_nxt   = r_cnt - 2'd1;
                    // The header is not part of the payload word.
                    if (!r_is_hdr)
                        w_data_nxt = {8'h00, r_data[15:8]};
                    w_state_nxt = (r_cnt == 2'd1) ? ST_DONE : ST_SEND;
                end
            end
            ST_DONE: begin
                w_done_nxt       = 3'b001 << r_id;
                w_last_grant_nxt = r_id;
                w_state_nxt      = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 2'd2;
            r_id         <= 2'd0;
            r_len        <= 2'd0;
            r_cnt        <= 2'd0;
            r_is_hdr     <= 1'b0;
            r_data       <= 16'h0000;
            r_tx_data    <= 8'h00;
            r_tx_go      <= 1'b0;
            r_ack        <= 3'b000;
            r_done       <= 3'b000;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_id         <= w_id_nxt;
            r_len        <= w_len_nxt;
            r_cnt        <= w_cnt_nxt;
            r_is_hdr     <= w_is_hdr_nxt;
            r_data       <= w_data_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_go      <= w_tx_go_nxt;
            r_ack        <= w_ack_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign ack     = r_ack;
    assign done    = r_done;
    assign tx_data = r_tx_data;
    assign tx_go   = r_tx_go;
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire
